uno_seq: RTL and testbench

//  Request sequencer directly upstream of the uno PE. Accepts one op per valid/ready handshake
//  and drives uno's op/X/Y/Z/coeff/first/last/acc_en pins cycle by cycle:
//   - MAC (op=00): single issue.
//   - div/exp/log (op=01/10/11): ORDER Horner coefficient steps plus one scale/offset step.

---
 rtl/uno_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_uno_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uno_seq.sv
// uno_seq: request sequencer in front of the uno PE. It issues a MAC in one step, or a nonlinear op as ORDER Horner steps plus one scale step, then returns the captured mac_o.
// Optional macro UNO_SEQ_COEFF_WR_EN turns the coefficient ROM into a register table that can be written through the cfg_* ports.
module uno_seq #(
  parameter int BW      = 12,
  parameter int ORDER   = 3,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [BW-1:0]     req_x,
  input  logic [BW-1:0]     req_y,
  input  logic [2*BW-1:0]   req_z,
  input  logic              req_acc,
  input  logic [2*BW-1:0]   mac_o,
  output logic [1:0]        op,
  output logic [BW-1:0]     X,
  output logic [BW-1:0]     Y,
  output logic [2*BW-1:0]   Z,
  output logic [BW-1:0]     coeff,
  output logic              first_cycle,
  output logic              last_cycle,
  output logic              acc_en,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*BW-1:0]   res_data
`ifdef UNO_SEQ_COEFF_WR_EN
  ,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_op,
  input  logic [$clog2(ORDER)-1:0]  cfg_idx,
  input  logic [BW-1:0]             cfg_data
`endif
);

  localparam int SW = $clog2(ORDER + 1);
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [SW-1:0] STEP_LAST  = SW'(ORDER);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOLD} state_t;

  state_t              r_state;
  logic [SW-1:0]       r_step;
  logic [DW-1:0]       r_drain;
  logic                r_req_ready;
  logic [1:0]          r_op;
  logic [BW-1:0]       r_x;
  logic [BW-1:0]       r_y;
  logic [2*BW-1:0]     r_z;
  logic [BW-1:0]       r_coeff;
  logic                r_first;
  logic                r_last;
  logic                r_acc_en;
  logic                r_res_valid;
  logic [2*BW-1:0]     r_res_data;

  logic [1:0]          w_nxt_op;
  logic [SW-1:0]       w_nxt_k;
  logic [BW-1:0]       w_nxt_coef;

  // Q4.8 power-on coefficients; entries beyond k=2 are zero for larger ORDER.
  function automatic logic [BW-1:0] coef_default(input logic [1:0] f_op, input logic [SW-1:0] f_k);
    logic [BW-1:0] v;
    v = '0;
    case (f_op)
      2'b01: begin
        if (f_k == SW'(0))      v = BW'(12'h100);
        else if (f_k == SW'(1)) v = BW'(12'h0C0);
        else if (f_k == SW'(2)) v = BW'(12'h090);
        else                    v = '0;
      end
      2'b10: begin
        if (f_k == SW'(0))      v = BW'(12'h100);
        else if (f_k == SW'(1)) v = BW'(12'h100);
        else if (f_k == SW'(2)) v = BW'(12'h080);
        else                    v = '0;
      end
      2'b11: begin
        if (f_k == SW'(0))      v = BW'(12'h000);
        else if (f_k == SW'(1)) v = BW'(12'h100);
        else if (f_k == SW'(2)) v = BW'(12'h080);
        else                    v = '0;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Select which (op, step) the next registered coefficient belongs to.
  always_comb begin
    w_nxt_op = r_op;
    w_nxt_k  = r_step + SW'(1);
    if (r_state == S_IDLE) begin
      w_nxt_op = req_op;
      w_nxt_k  = '0;
    end else begin
      w_nxt_op = r_op;
      w_nxt_k  = r_step + SW'(1);
    end
  end

`ifdef UNO_SEQ_COEFF_WR_EN
  localparam int KW = $clog2(ORDER);

  logic [BW-1:0] r_coef [3][ORDER];
  logic          w_cfg_hit;

  assign w_cfg_hit = cfg_we && (cfg_op != 2'b00) && ({1'b0, cfg_idx} < (KW+1)'(ORDER));

  // Writable coefficient table, reset to the ROM defaults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < ORDER; k++) begin
          r_coef[i][k] <= coef_default(2'(i + 1), SW'(k));
        end
      end
    end else if (w_cfg_hit) begin
      r_coef[cfg_op - 2'd1][cfg_idx] <= cfg_data;
    end
  end

  // A write landing on the same edge as the coefficient register load is forwarded,
  // so the step in the following cycle sees the table as it stands in that cycle.
  always_comb begin
    w_nxt_coef = '0;
    if ((w_nxt_op != 2'b00) && (w_nxt_k < STEP_LAST)) begin
      if (w_cfg_hit && (cfg_op == w_nxt_op) && (cfg_idx == w_nxt_k[KW-1:0])) begin
        w_nxt_coef = cfg_data;
      end else begin
        w_nxt_coef = r_coef[w_nxt_op - 2'd1][w_nxt_k[KW-1:0]];
      end
    end else begin
      w_nxt_coef = '0;
    end
  end
`else
  // Constant coefficient ROM lookup.
  always_comb begin
    w_nxt_coef = '0;
    if ((w_nxt_op != 2'b00) && (w_nxt_k < STEP_LAST)) begin
      w_nxt_coef = coef_default(w_nxt_op, w_nxt_k);
    end else begin
      w_nxt_coef = '0;
    end
  end
`endif

  // Sequencer FSM; every uno pin and result output is a register loaded here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_drain     <= '0;
      r_req_ready <= 1'b0;
      r_op        <= 2'b00;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_coeff     <= '0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_acc_en    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_state     <= S_ISSUE;
            r_req_ready <= 1'b0;
            r_step      <= '0;
            r_op        <= req_op;
            r_x         <= req_x;
            r_y         <= req_y;
            r_z         <= req_z;
            r_coeff     <= w_nxt_coef;
            r_first     <= (req_op != 2'b00);
            r_last      <= 1'b0;
            r_acc_en    <= (req_op == 2'b00) ? req_acc : 1'b0;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_first <= 1'b0;
          if ((r_op == 2'b00) || (r_step == STEP_LAST)) begin
            r_state  <= S_DRAIN;
            r_drain  <= '0;
            r_last   <= 1'b0;
            r_acc_en <= 1'b0;
          end else begin
            r_step  <= r_step + SW'(1);
            r_coeff <= w_nxt_coef;
            r_last  <= (w_nxt_k == STEP_LAST);
          end
        end
        S_DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            r_res_data  <= mac_o;
            r_res_valid <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_drain <= r_drain + DW'(1);
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_res_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b0;
          r_first     <= 1'b0;
          r_last      <= 1'b0;
          r_acc_en    <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign op          = r_op;
  assign X           = r_x;
  assign Y           = r_y;
  assign Z           = r_z;
  assign coeff       = r_coeff;
  assign first_cycle = r_first;
  assign last_cycle  = r_last;
  assign acc_en      = r_acc_en;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;

endmodule

// File: tb/tb_uno_seq.sv
// Self-checking bench for uno_seq: directed scenarios plus randomized ops against a cycle-level reference model.
`timescale 1ns/1ps
module tb_uno_seq;
  localparam int BW      = 12;
  localparam int ORDER   = 3;
  localparam int MAC_LAT = 1;
  localparam int RW      = 2 * BW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [BW-1:0] req_x = '0;
  logic [BW-1:0] req_y = '0;
  logic [RW-1:0] req_z = '0;
  logic          req_acc = 1'b0;
  logic [RW-1:0] mac_o = '0;
  logic [1:0]    op;
  logic [BW-1:0] X, Y, coeff;
  logic [RW-1:0] Z;
  logic          first_cycle, last_cycle, acc_en;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [RW-1:0] res_data;
`ifdef UNO_SEQ_COEFF_WR_EN
  logic                     cfg_we = 1'b0;
  logic [1:0]               cfg_op = 2'b00;
  logic [$clog2(ORDER)-1:0] cfg_idx = '0;
  logic [BW-1:0]            cfg_data = '0;
`endif

  always #5 clk = ~clk;

  uno_seq #(.BW(BW), .ORDER(ORDER), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_acc(req_acc),
    .mac_o(mac_o), .op(op), .X(X), .Y(Y), .Z(Z), .coeff(coeff),
    .first_cycle(first_cycle), .last_cycle(last_cycle), .acc_en(acc_en),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`ifdef UNO_SEQ_COEFF_WR_EN
    , .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_idx(cfg_idx), .cfg_data(cfg_data)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [BW-1:0] tb_coef [4][ORDER];
  logic [RW-1:0] last_res = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge; mac_o carries noise unless a test overrides it.
  task automatic tick();
    @(negedge clk);
    mac_o = RW'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {op, X, Y, Z, coeff, first_cycle, last_cycle, acc_en, res_valid, res_data, req_ready}, 64'd0);
  endtask

  // Drive one request end to end and check every cycle against the model.
  task automatic run_op(input logic [1:0] o, input logic [BW-1:0] x, input logic [BW-1:0] y,
                        input logic [RW-1:0] z, input logic a, input int hold);
    logic [RW-1:0] exp_res;
    logic [BW-1:0] exp_coef;
    int n_issue;
    int waited;
    n_issue = (o == 2'b00) ? 1 : ORDER + 1;
    if (o == 2'b00) begin
      exp_res = RW'(x) * RW'(y) + z;
      if (a) exp_res = exp_res + last_res;
    end else begin
      exp_res = RW'($urandom);
    end
    req_op = o; req_x = x; req_y = y; req_z = z; req_acc = a; req_valid = 1'b1;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    check_eq("req_ready_before_accept", req_ready, 1'b1);
    for (int i = 0; i < n_issue; i++) begin
      tick();
      req_valid = 1'($urandom); req_op = 2'($urandom); req_x = BW'($urandom);
      req_z = RW'($urandom); req_acc = 1'($urandom); res_ready = 1'($urandom);
      exp_coef = (o != 2'b00 && i < ORDER) ? tb_coef[o][i] : '0;
      check_eq("issue_op", op, o);
      check_eq("issue_xyz", {X, Y, Z}, {x, y, z});
      check_eq("issue_coeff", coeff, exp_coef);
      check_eq("issue_first", first_cycle, (o != 2'b00) && (i == 0));
      check_eq("issue_last", last_cycle, (o != 2'b00) && (i == ORDER));
      check_eq("issue_acc_en", acc_en, (o == 2'b00) ? a : 1'b0);
      check_eq("issue_busy", {req_ready, res_valid}, 2'b00);
    end
    for (int d = 1; d <= MAC_LAT; d++) begin
      tick();
      check_eq("drain_res_valid", res_valid, 1'b0);
      check_eq("drain_pins", {first_cycle, last_cycle, acc_en, req_ready}, 4'b0000);
      if (d == MAC_LAT) mac_o = exp_res;
    end
    tick();
    check_eq("res_valid_rise", res_valid, 1'b1);
    check_eq("res_data", res_data, exp_res);
    last_res = exp_res;
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0; req_valid = 1'b1; req_op = 2'($urandom); req_x = BW'($urandom);
      tick();
      check_eq("hold_valid", res_valid, 1'b1);
      check_eq("hold_data", res_data, exp_res);
      check_eq("hold_req_ready", req_ready, 1'b0);
      check_eq("hold_pins", {first_cycle, last_cycle, acc_en}, 3'b000);
      check_eq("hold_regs", {op, X, coeff}, {o, x, {BW{1'b0}}});
    end
    res_ready = 1'b1; req_valid = 1'b0;
    tick();
    res_ready = 1'b0;
    check_eq("pop_res_valid", res_valid, 1'b0);
    check_eq("pop_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < ORDER; k++) tb_coef[0][k] = '0;
    tb_coef[1][0] = 12'h100; tb_coef[1][1] = 12'h0C0; tb_coef[1][2] = 12'h090;
    tb_coef[2][0] = 12'h100; tb_coef[2][1] = 12'h100; tb_coef[2][2] = 12'h080;
    tb_coef[3][0] = 12'h000; tb_coef[3][1] = 12'h100; tb_coef[3][2] = 12'h080;

    // Reset behaviour.
    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    #1;
    check_eq("req_ready_at_release", req_ready, 1'b0);
    tick();
    check_eq("req_ready_after_release", req_ready, 1'b1);
    check_eq("idle_res_valid", res_valid, 1'b0);

    // Directed MAC, exp, and backpressure scenarios.
    run_op(2'b00, 12'h003, 12'h004, 24'h000010, 1'b0, 0);
    run_op(2'b10, 12'h1A0, 12'h000, 24'h000000, 1'b0, 1);
    run_op(2'b01, 12'h055, 12'h0AA, 24'h000000, 1'b0, 10);
    run_op(2'b00, 12'h010, 12'h010, 24'h000001, 1'b1, 0);

    // Reset during step 1 of a log op aborts it.
    req_op = 2'b11; req_x = 12'h123; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check_eq("abort_step1_coeff", coeff, tb_coef[3][1]);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_outputs");
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("abort_req_ready", req_ready, 1'b1);
    for (int c = 0; c < 5; c++) begin
      res_ready = 1'($urandom);
      tick();
      check_eq("abort_no_result", {res_valid, first_cycle, last_cycle}, 3'b000);
    end
    res_ready = 1'b0;
    last_res = '0;

`ifdef UNO_SEQ_COEFF_WR_EN
    // Coefficient writes, including two that must be dropped.
    for (int k = 0; k < 3; k++) begin
      cfg_we = 1'b1; cfg_op = 2'b01; cfg_idx = 2'(k); cfg_data = BW'(12'h011 * (k + 1));
      tick();
      tb_coef[1][k] = BW'(12'h011 * (k + 1));
    end
    cfg_op = 2'b00; cfg_idx = 2'd0; cfg_data = 12'hFFF;
    tick();
    cfg_op = 2'b10; cfg_idx = 2'd3; cfg_data = 12'hFFF;
    tick();
    cfg_we = 1'b0;
    run_op(2'b01, 12'h001, 12'h002, 24'h000000, 1'b0, 0);
    run_op(2'b10, 12'h001, 12'h002, 24'h000000, 1'b0, 0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      run_op(2'($urandom), BW'($urandom), BW'($urandom), RW'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
